// File: rtl/transmit_slot_dispatcher.sv
// Transmit slot dispatcher: drains the switch-fabric output FIFO and hands whole frames
// to transmit queue slots, picking free slots in round-robin order.
module transmit_slot_dispatcher #(
  parameter int unsigned TRANSMIT_QUE_SLOTS = 4,
  parameter int unsigned FRAME_COUNT_WIDTH  = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [8:0]                            pop_data,
  input  logic                                  pop_data_valid,
  output logic                                  pop_ready,
  input  logic [TRANSMIT_QUE_SLOTS-1:0]         slot_free,
  input  logic [TRANSMIT_QUE_SLOTS-1:0]         slot_ready,
  output logic [8:0]                            slot_data,
  output logic [TRANSMIT_QUE_SLOTS-1:0]         slot_data_valid,
  output logic [$clog2(TRANSMIT_QUE_SLOTS)-1:0] active_slot,
  output logic                                  frame_done,
  output logic [FRAME_COUNT_WIDTH-1:0]          frame_count
);

  localparam int unsigned SlotW = $clog2(TRANSMIT_QUE_SLOTS);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(TRANSMIT_QUE_SLOTS - 1);

  typedef enum logic {StIdle, StPassthrough} state_e;

  state_e                        state;
  logic [SlotW-1:0]              next_slot;
  logic [TRANSMIT_QUE_SLOTS-1:0] strobe;
  logic                          xfer;

  assign next_slot = (active_slot == LastSlot) ? '0 : active_slot + 1'b1;
  assign strobe    = {{(TRANSMIT_QUE_SLOTS - 1){1'b0}}, 1'b1} << active_slot;

  // Only slot_ready gates a word once the slot is claimed; slot_free is ignored mid-frame.
  assign xfer      = (state == StPassthrough) && pop_data_valid && slot_ready[active_slot];
  assign pop_ready = xfer && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= StIdle;
      active_slot     <= '0;
      slot_data       <= '0;
      slot_data_valid <= '0;
      frame_done      <= 1'b0;
      frame_count     <= '0;
    end else begin
      slot_data_valid <= '0;
      frame_done      <= 1'b0;
      case (state)
        StIdle: begin
          // Claim cycle: no word moves while the candidate slot is being taken.
          if (slot_free[active_slot]) begin
            state <= StPassthrough;
          end else begin
            active_slot <= next_slot;
          end
        end
        StPassthrough: begin
          if (xfer) begin
            slot_data       <= pop_data;
            slot_data_valid <= strobe;
            if (pop_data[8]) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
              state       <= StIdle;
              active_slot <= next_slot;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_transmit_slot_dispatcher.sv
// Scoreboard bench for transmit_slot_dispatcher: a frame-level reference model predicts
// each slot write; a negedge monitor pops and compares what the DUT presents.
module tb_transmit_slot_dispatcher;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int SW = $clog2(N);

  logic          clock = 1'b0;
  logic          reset;
  logic [8:0]    pop_data;
  logic          pop_data_valid;
  logic          pop_ready;
  logic [N-1:0]  slot_free;
  logic [N-1:0]  slot_ready;
  logic [8:0]    slot_data;
  logic [N-1:0]  slot_data_valid;
  logic [SW-1:0] active_slot;
  logic          frame_done;
  logic [CW-1:0] frame_count;

  always #5 clock = ~clock;

  transmit_slot_dispatcher #(
    .TRANSMIT_QUE_SLOTS(N),
    .FRAME_COUNT_WIDTH (CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pop_data       (pop_data),
    .pop_data_valid (pop_data_valid),
    .pop_ready      (pop_ready),
    .slot_free      (slot_free),
    .slot_ready     (slot_ready),
    .slot_data      (slot_data),
    .slot_data_valid(slot_data_valid),
    .active_slot    (active_slot),
    .frame_done     (frame_done),
    .frame_count    (frame_count)
  );

  typedef struct {
    int         slot;
    logic [8:0] word;
  } exp_t;

  logic [8:0] src_q[$];
  exp_t       exp_q[$];
  bit         gate;
  bit         started = 0;
  int         total = 0;
  int         bad = 0;

  // Reference model: which slot owns the current frame, and where the scan pointer is.
  bit         m_claimed = 0;
  int         m_ptr = 0;
  int         m_count = 0;
  logic [8:0] m_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic present();
    pop_data_valid = gate && (src_q.size() != 0);
    pop_data       = (src_q.size() != 0) ? src_q[0] : 9'h000;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    present();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic push_frame(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) src_q.push_back({(i == len - 1), 8'(base + 8'(i))});
    present();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || m_claimed) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", n, -1);
    step();
    step();
  endtask

  always @(posedge clock) begin
    exp_t e;
    if (reset) begin
      m_claimed = 0;
      m_ptr     = 0;
      m_count   = 0;
      m_data    = '0;
      src_q.delete();
    end else if (!m_claimed) begin
      if (slot_free[m_ptr]) m_claimed = 1;
      else m_ptr = (m_ptr + 1) % N;
    end else if (pop_data_valid && slot_ready[m_ptr]) begin
      e.slot = m_ptr;
      e.word = pop_data;
      exp_q.push_back(e);
      m_data = pop_data;
      void'(src_q.pop_front());
      if (pop_data[8]) begin
        m_claimed = 0;
        m_ptr     = (m_ptr + 1) % N;
        m_count   = (m_count + 1) % (1 << CW);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    bit   exp_pr;
    exp_pr = !reset && m_claimed && pop_data_valid && slot_ready[m_ptr];
    chk("pop_ready", int'(pop_ready), int'(exp_pr));
    if (started) begin
      chk("active_slot", int'(active_slot), m_ptr);
      chk("frame_count", int'(frame_count), m_count);
      chk("slot_data", int'(slot_data), int'(m_data));
      if (slot_data_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", int'(slot_data_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe", int'(slot_data_valid), 1 << e.slot);
          chk("word", int'(slot_data), int'(e.word));
          chk("frame_done", int'(frame_done), int'(e.word[8]));
        end
      end else begin
        chk("idle_frame_done", int'(frame_done), 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("missing_strobe", 0, 1 << e.slot);
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    gate       = 1'b1;
    slot_free  = '1;
    slot_ready = '1;
    src_q.push_back(9'h0AA);
    present();
    @(posedge clock);
    started = 1;
    #1;
    src_q.push_back(9'h0AA);
    present();
    step();
    reset = 1'b0;

    // Single 3-word frame into slot 0.
    src_q.push_back(9'h011);
    src_q.push_back(9'h022);
    src_q.push_back(9'h133);
    present();
    drain(50);

    // Round-robin over four 1-word frames, starting from slot 0.
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back(9'(9'h1A0 + i));
    present();
    drain(50);

    // Busy skip: only slots 1 and 3 free.
    do_reset();
    slot_free = 4'b1010;
    src_q.push_back(9'h055);
    src_q.push_back(9'h166);
    src_q.push_back(9'h177);
    present();
    drain(50);
    slot_free = '1;

    // Backpressure on slot 0 for three cycles mid-frame.
    do_reset();
    push_frame(4, 8'h40);
    step();
    step();
    step();
    slot_ready = 4'b1110;
    step();
    step();
    step();
    slot_ready = '1;
    drain(50);

    // Reset after two of four words, then 17 frames to wrap the counter.
    do_reset();
    push_frame(4, 8'h80);
    step();
    step();
    step();
    do_reset();
    for (int i = 0; i < 17; i++) push_frame(1, 8'(8'hC0 + i));
    drain(200);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      slot_free  = N'($urandom);
      slot_ready = N'($urandom | $urandom);
      gate       = ($urandom_range(0, 3) != 0);
      if (src_q.size() < 6) push_frame(int'($urandom_range(1, 5)), 8'($urandom));
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end
    slot_free  = '1;
    slot_ready = '1;
    gate       = 1'b1;
    present();
    drain(500);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/transmit_slot_dispatcher.md
Name: transmit_slot_dispatcher

Overview:
- Transmit-side counterpart of the receive slot arbiter.
- Pops 9-bit words (bits 7:0 data, bit 8 end-of-frame) from the single switch-fabric output FIFO and delivers whole frames to one of TRANSMIT_QUE_SLOTS transmit queue slots.
- Slots are chosen round-robin among slots reporting free. A frame is never split across slots.

Parameters:
- TRANSMIT_QUE_SLOTS, 4, number of transmit queue slots; legal range 2..16.
- FRAME_COUNT_WIDTH, 16, width of the completed-frame counter.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pop_data  input  9  head word of the source FIFO; bit 8 = last word of frame.
- pop_data_valid  input  1  source FIFO non-empty; pop_data is valid.
- pop_ready  output  1  combinational pop strobe; the word is consumed this cycle.
- slot_free  input  TRANSMIT_QUE_SLOTS  per-slot: slot can accept a new frame.
- slot_ready  input  TRANSMIT_QUE_SLOTS  per-slot: slot can accept a word this cycle.
- slot_data  output  9  registered word to the slots, shared bus.
- slot_data_valid  output  TRANSMIT_QUE_SLOTS  registered one-hot write strobe.
- active_slot  output  $clog2(TRANSMIT_QUE_SLOTS)  registered index of the current/next candidate slot.
- frame_done  output  1  registered one-cycle pulse when the last word of a frame is written.
- frame_count  output  FRAME_COUNT_WIDTH  registered count of completed frames.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - state=S_IDLE, active_slot=0.
  - slot_data=0, slot_data_valid=0, frame_done=0, frame_count=0.
  - pop_ready is forced 0 while reset=1.
- S_IDLE:
  - pop_ready=0.
  - If slot_free[active_slot]=1: go to S_PASSTHROUGH and keep active_slot. This is the claim cycle; no word moves.
  - Else: active_slot advances by 1, wrapping from TRANSMIT_QUE_SLOTS-1 to 0. Each slot is examined one per cycle.
- S_PASSTHROUGH:
  - Transfer condition: pop_data_valid=1 AND slot_ready[active_slot]=1.
  - On transfer:
    - pop_ready=1 in the same cycle (combinational).
    - Next edge: slot_data<=pop_data, slot_data_valid<=(1<<active_slot).
  - Latency is 1 cycle from pop to slot write strobe.
  - No transfer: pop_ready=0, slot_data_valid<=0, slot_data holds its last value, state and active_slot hold (stall).
  - Transfer with pop_data[8]=1:
    - Go to S_IDLE; active_slot advances with wrap.
    - frame_done<=1 for one cycle, coincident with the last slot_data_valid.
    - frame_count<=frame_count+1, wrapping at all-ones to 0.
  - slot_free changes on the active slot during a frame are ignored. Only slot_ready gates transfer.
  - Strobes to slots other than active_slot are always 0; slot_data_valid is always one-hot or zero.
- Single-word frame (first word has bit 8=1): claim cycle, one transfer, return to S_IDLE. Minimum 2 cycles per frame.
- Back-to-back frames: after a frame ends, the next frame goes to the next free slot in round-robin order, never immediately back to the same slot while another slot is free.
- All slots busy: S_IDLE scans continuously, pop_ready stays 0, no words are lost.
- Reset mid-frame: takes effect immediately and abandons the partial frame. The source FIFO and slots share the reset and must also clear.
- frame_done and slot_data_valid are 0 in every cycle with no transfer.

Test Plan:
- Reset sequence: assert reset 2 cycles with pop_data_valid=1 -> pop_ready=0, all outputs 0, active_slot=0.
- Single 3-word frame 0x011, 0x022, 0x133; all slots free/ready -> claim at cycle 1; slot_data_valid=4'b0001 on cycles 3..5 carrying 0x011, 0x022, 0x133; frame_done on cycle 5; frame_count=1; active_slot=1.
- Round-robin: four back-to-back 1-word frames 0x1A0..0x1A3, all free -> strobes 0001, 0010, 0100, 1000 in order, then active_slot wraps to 0; frame_count=4.
- Busy skip: slot_free=4'b1010, active_slot=0 -> idle scan 0→1, frame 0x055, 0x166 written to slot 1 (strobe 0010); next frame skips slot 2 and goes to slot 3.
- Backpressure: slot_ready[0] drops for 3 cycles mid-frame -> pop_ready=0 and no strobes for exactly those cycles; word order preserved, nothing duplicated or dropped.
- Reset mid-frame after 2 of 4 words, then counter wrap (FRAME_COUNT_WIDTH=4, 17 frames) -> immediate return to reset values; frame_count reads 1 after 17 frames.
